// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata, imem_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata, imem_err
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, single-outstanding imem requests, presents {pc, inst, traps} to IF/ID.
// Define COTM32_IF_HOLD_BUF_EN to hold a stalled response in a 1-entry buffer instead of refetching it.
//
// state  | meaning
// S_REQ  | issue request at pc (or present misaligned trap)
// S_WAIT | request granted, waiting for response
// S_HOLD | stalled response held in buffer (COTM32_IF_HOLD_BUF_EN only)
// S_DROP | redirected while a request was in flight; discard its response
// S_TRAP | trap presented and accepted; idle until redirect
module if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INST_NOP     = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    if_stage_if.master  imem,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_t_inst_addr_misaligned,
    output logic        o_t_inst_access_fault
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
`ifdef COTM32_IF_HOLD_BUF_EN
        S_HOLD,
`endif
        S_DROP,
        S_TRAP
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
`ifdef COTM32_IF_HOLD_BUF_EN
    logic [31:0] r_buf_inst;
    logic        r_buf_err;
`endif

    logic        w_misaligned;
    logic        w_req;
    logic        w_present;
    logic        w_err;
    logic        w_mis;
    logic [31:0] w_inst;
    logic        w_valid;
    logic [31:0] w_pc_inc;
    logic        w_in_flight;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_req        = !i_rst && (r_state == S_REQ) && !w_misaligned;
    assign w_pc_inc     = r_pc + 32'd4;

    // A redirect must drop whatever response is still owed to us.
    assign w_in_flight  = ((r_state == S_WAIT) && !imem.imem_rvalid)
                       || ((r_state == S_DROP) && !imem.imem_rvalid)
                       || (w_req && imem.imem_gnt);

    always_comb begin
        w_present = 1'b0;
        w_err     = 1'b0;
        w_mis     = 1'b0;
        w_inst    = INST_NOP;
        case (r_state)
            S_REQ: begin
                if (w_misaligned) begin
                    w_present = 1'b1;
                    w_mis     = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    w_present = 1'b1;
                    w_err     = imem.imem_err;
                    w_inst    = imem.imem_err ? INST_NOP : imem.imem_rdata;
                end
            end
`ifdef COTM32_IF_HOLD_BUF_EN
            S_HOLD: begin
                w_present = 1'b1;
                w_err     = r_buf_err;
                w_inst    = r_buf_inst;
            end
`endif
            default: ;
        endcase
    end

    assign w_valid                  = w_present && !i_redirect && !i_rst;
    assign o_valid                  = w_valid;
    assign o_pc                     = i_rst ? 32'd0 : r_pc;
    assign o_inst                   = w_valid ? w_inst : INST_NOP;
    assign o_t_inst_addr_misaligned = w_valid && w_mis;
    assign o_t_inst_access_fault    = w_valid && w_err;
    assign imem.imem_req            = w_req;
    assign imem.imem_addr           = r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_VECTOR;
`ifdef COTM32_IF_HOLD_BUF_EN
            r_buf_inst <= INST_NOP;
            r_buf_err  <= 1'b0;
`endif
        end else if (i_redirect) begin
            r_pc       <= i_redirect_pc;
            r_state    <= w_in_flight ? S_DROP : S_REQ;
`ifdef COTM32_IF_HOLD_BUF_EN
            r_buf_inst <= INST_NOP;
            r_buf_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_misaligned) begin
                        if (!i_stall) r_state <= S_TRAP;
                    end else if (imem.imem_gnt) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!i_stall) begin
                            if (imem.imem_err) begin
                                r_state <= S_TRAP;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_REQ;
                            end
                        end else begin
`ifdef COTM32_IF_HOLD_BUF_EN
                            r_buf_inst <= w_inst;
                            r_buf_err  <= imem.imem_err;
                            r_state    <= S_HOLD;
`else
                            // Response is thrown away; same pc is fetched again.
                            r_state    <= S_REQ;
`endif
                        end
                    end
                end
`ifdef COTM32_IF_HOLD_BUF_EN
                S_HOLD: begin
                    if (!i_stall) begin
                        if (r_buf_err) begin
                            r_state <= S_TRAP;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_REQ;
                        end
                    end
                end
`endif
                S_DROP: begin
                    if (imem.imem_rvalid) r_state <= S_REQ;
                end
                S_TRAP:  ;
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written corner sequences, random traffic vs a transaction-level model.
module tb_if_stage;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'd0;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_mis;
    logic        o_flt;

    if_stage_if bus ();

    if_stage dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_stall                  (stall),
        .i_redirect               (redir),
        .i_redirect_pc            (rpc),
        .imem                     (bus),
        .o_valid                  (o_valid),
        .o_pc                     (o_pc),
        .o_inst                   (o_inst),
        .o_t_inst_addr_misaligned (o_mis),
        .o_t_inst_access_fault    (o_flt)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model: where the fetcher is, whether a response is owed/killed/held/trapped.
    logic [31:0] m_pc = 32'd0;
    bit          m_out = 0, m_kill = 0, m_trap = 0, m_held = 0;

    // Memory: responds mem_lat cycles after a grant with addr^KEY, error at addresses ending in 0x40.
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'd0;
    bit          err_en = 0;

    logic        s_valid, s_req, s_mis, s_flt;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic bit err_at(logic [31:0] a);
        return err_en && (a[7:0] == 8'h40);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cycle(bit r, bit st, bit rd, logic [31:0] rp, bit g);
        bit mis, idle, e_req, resp, pres, flt, rv, nout;
        @(negedge clk);
        rst = r; stall = st; redir = rd; rpc = rp;
        rv = !r && (mem_cnt == 1);
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;
        bus.imem_err    = rv && err_at(mem_addr);
        #1;
        s_valid = o_valid; s_pc = o_pc; s_inst = o_inst; s_mis = o_mis; s_flt = o_flt;
        s_req = bus.imem_req; s_addr = bus.imem_addr;
        mis = 0; idle = 0; e_req = 0; resp = 0; pres = 0; flt = 0;
        if (r) begin
            chk("rst_valid", s_valid, 0);
            chk("rst_req", s_req, 0);
            chk("rst_pc", s_pc, 0);
            chk("rst_inst", s_inst, NOP);
            chk("rst_mis", s_mis, 0);
            chk("rst_flt", s_flt, 0);
        end else begin
            mis   = (m_pc[1:0] != 2'b00);
            idle  = !m_out && !m_trap && !m_held;
            e_req = idle && !mis;
            resp  = m_out && !m_kill && rv;
            pres  = m_held || resp || (idle && mis);
            flt   = (m_held || resp) && err_at(m_pc);
            chk("valid", s_valid, pres && !rd);
            chk("req", s_req, e_req);
            chk("addr", s_addr, m_pc);
            if (pres && !rd) begin
                chk("pc", s_pc, m_pc);
                chk("inst", s_inst, ((mis && idle) || flt) ? NOP : (m_pc ^ KEY));
                chk("misaligned", s_mis, mis && idle);
                chk("fault", s_flt, flt);
            end
        end
        @(posedge clk);
        if (mem_cnt > 0) mem_cnt--;
        if (r) begin
            m_pc = 32'd0; m_out = 0; m_kill = 0; m_trap = 0; m_held = 0;
            mem_cnt = 0;
        end else begin
            if (s_req && g) begin
                mem_cnt  = mem_lat;
                mem_addr = s_addr;
            end
            if (rd) begin
                nout   = (m_out && !rv) || (e_req && g);
                m_out  = nout;
                m_kill = nout;
                m_pc   = rp;
                m_held = 0;
                m_trap = 0;
            end else if (pres && !st) begin
                if ((mis && idle) || flt) m_trap = 1;
                else m_pc = m_pc + 32'd4;
                m_out = 0; m_held = 0; m_kill = 0;
            end else if (pres && st) begin
                if (resp) begin
`ifdef COTM32_IF_HOLD_BUF_EN
                    m_held = 1;
`endif
                    m_out = 0;
                end
            end else if (m_out && rv) begin
                m_out = 0; m_kill = 0;
            end else if (e_req && g) begin
                m_out = 1; m_kill = 0;
            end
        end
    endtask

    typedef struct {
        bit          st;
        bit          gnt;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit found;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.imem_err = 0;

        tbl[0] = '{0, 1, 1, 32'h0, 0, 32'h0, 32'h0};
        tbl[1] = '{0, 1, 0, 32'h0, 1, 32'h0, 32'hA5A5_0000};
        tbl[2] = '{0, 1, 1, 32'h4, 0, 32'h0, 32'h0};
        tbl[3] = '{0, 1, 0, 32'h4, 1, 32'h4, 32'hA5A5_0004};
        tbl[4] = '{0, 1, 1, 32'h8, 0, 32'h0, 32'h0};
        tbl[5] = '{1, 0, 0, 32'h8, 1, 32'h8, 32'hA5A5_0008};

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, tbl[i].st, 0, 0, tbl[i].gnt);
            chk("tbl_req", s_req, tbl[i].e_req);
            chk("tbl_addr", s_addr, tbl[i].e_addr);
            chk("tbl_valid", s_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk("tbl_pc", s_pc, tbl[i].e_pc);
                chk("tbl_inst", s_inst, tbl[i].e_inst);
            end
        end

        // Stall continues two more cycles over the pc=8 response, released on the third.
        cycle(0, 1, 0, 0, 0);
`ifdef COTM32_IF_HOLD_BUF_EN
        chk("hold_valid", s_valid, 1); chk("hold_req", s_req, 0); chk("hold_inst", s_inst, 32'hA5A5_0008);
`else
        chk("refetch_valid", s_valid, 0); chk("refetch_req", s_req, 1); chk("refetch_addr", s_addr, 32'h8);
`endif
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
`ifdef COTM32_IF_HOLD_BUF_EN
        chk("hold_last_valid", s_valid, 1); chk("hold_last_pc", s_pc, 32'h8);
        cycle(0, 0, 0, 0, 1);
        chk("after_hold_addr", s_addr, 32'hC);
`else
        chk("reissue_req", s_req, 1); chk("reissue_addr", s_addr, 32'h8);
        cycle(0, 0, 0, 0, 1);
        chk("reissue_valid", s_valid, 1); chk("reissue_pc", s_pc, 32'h8);
`endif

        // Redirect while the pc=4 fetch is in flight (2-cycle memory).
        mem_lat = 2;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("rd_req4", s_addr, 32'h4);
        cycle(0, 0, 1, 32'h100, 1);
        chk("rd_valid", s_valid, 0);
        cycle(0, 0, 0, 0, 0);
        chk("drop_valid", s_valid, 0); chk("drop_req", s_req, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rd_newreq", s_req, 1); chk("rd_newaddr", s_addr, 32'h100);
        mem_lat = 1;

        // Misaligned redirect target.
        cycle(0, 0, 1, 32'h102, 0);
        cycle(0, 0, 0, 0, 1);
        chk("mis_req", s_req, 0); chk("mis_valid", s_valid, 1);
        chk("mis_inst", s_inst, NOP); chk("mis_flag", s_mis, 1);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 0, 1);
            chk("trap_idle_valid", s_valid, 0); chk("trap_idle_req", s_req, 0);
        end
        cycle(0, 0, 1, 32'h200, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rd200_req", s_req, 1); chk("rd200_addr", s_addr, 32'h200);

        // Access fault at 0x40.
        err_en = 1;
        cycle(0, 0, 1, 32'h3C, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, 0, 0, 0, 1);
            if (s_valid && s_pc == 32'h40) found = 1;
        end
        chk("err_seen", found, 1);
        chk("err_flt", s_flt, 1); chk("err_inst", s_inst, NOP);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1);
            chk("err_noreq", s_req, 0);
        end
        err_en = 0;

        // PC wrap.
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, 0, 1);
        chk("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 1);
        chk("wrap_valid", s_valid, 1);
        cycle(0, 0, 0, 0, 0);
        chk("wrap_req", s_req, 1); chk("wrap_addr0", s_addr, 32'h0);

        // Reset while waiting on memory.
        mem_lat = 2;
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rstw_valid", s_valid, 0); chk("rstw_req", s_req, 1); chk("rstw_addr", s_addr, 32'h0);

        // Random traffic.
        err_en = 1;
        for (int i = 0; i < 3000; i++) begin
            bit r, st, rd, g;
            logic [31:0] p;
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 15) == 0);
            g  = ($urandom_range(0, 3) != 0);
            p  = {$urandom_range(0, 127), 2'b00};
            if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) p = 32'hFFFF_FFF8;
            mem_lat = $urandom_range(1, 3);
            cycle(r, st, rd, p, g);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
